// File: rtl/mux_pkg.sv
// Shared types and defaults for the stream_mux_rr block.
// Holds the arbiter FSM state encoding and default geometry.
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CH    = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin request picker: first set request at or after ptr,
// searching upward modulo CH. Purely combinational.
module rr_pick #(
  parameter  int CH   = 8,
  localparam int SELW = $clog2(CH)
) (
  input  logic [CH-1:0]   i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_found,
  output logic [SELW-1:0] o_idx
);

  logic [2*CH-1:0] w_dbl;
  logic [CH-1:0]   w_rot;
  logic [SELW:0]   w_sum;

  // w_rot[i] is the request of channel (ptr+i) mod CH
  assign w_dbl = {i_req, i_req};
  assign w_rot = CH'(w_dbl >> i_ptr);

  always_comb begin
    o_found = 1'b0;
    w_sum   = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (SELW+1)'(i);
      end
    end
  end

  assign o_idx = (w_sum >= (SELW+1)'(CH)) ?
                 SELW'(w_sum - (SELW+1)'(CH)) :
                 w_sum[SELW-1:0];

endmodule

// File: rtl/stream_mux_rr.sv
// Packet-aware stream mux: fixed-select or round-robin arbitration,
// a grant held for a whole packet, one registered output stage.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CH    = DEF_CH,
  localparam int SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [CH-1:0]       in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_last,
  output logic [CH-1:0]       in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [SELW-1:0]     out_ch,
  input  logic                out_ready
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [SELW-1:0] r_g;
  logic [SELW-1:0] r_ptr;
  logic            r_lrr;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_ch;

  logic             w_ld;
  logic             w_rr_found;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_fix_v;
  logic             w_has;
  logic [SELW-1:0]  w_cand;
  logic             w_cvalid;
  logic             w_clast;
  logic [WIDTH-1:0] w_cdata;
  logic             w_acc;
  logic             w_rr_now;

  assign w_ld = !r_out_valid || out_ready;

  rr_pick #(
    .CH(CH)
  ) u_pick (
    .i_req  (in_valid),
    .i_ptr  (r_ptr),
    .o_found(w_rr_found),
    .o_idx  (w_rr_idx)
  );

  // out-of-range sel matches no channel, so it never grants
  always_comb begin
    w_fix_v = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SELW'(k)) w_fix_v = in_valid[k];
    end
  end

  always_comb begin
    w_has  = 1'b0;
    w_cand = '0;
    unique case (r_state)
      IDLE: begin
        if (mode) begin
          w_has  = w_rr_found;
          w_cand = w_rr_idx;
        end else begin
          w_has  = w_fix_v;
          w_cand = sel;
        end
      end
      LOCK: begin
        w_has  = 1'b1;
        w_cand = r_g;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_cvalid = 1'b0;
    w_clast  = 1'b0;
    w_cdata  = '0;
    for (int k = 0; k < CH; k++) begin
      if (w_cand == SELW'(k)) begin
        w_cvalid = in_valid[k];
        w_clast  = in_last[k];
        w_cdata  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_acc = w_has && w_ld && w_cvalid;

  assign in_ready = (rst_n && w_has && w_ld) ?
                    ({{(CH-1){1'b0}}, 1'b1} << w_cand) :
                    '0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_acc && !w_clast) w_state_nxt = LOCK;
      LOCK: if (w_acc && w_clast) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // a locked packet advances ptr per the mode it was granted under
  assign w_rr_now = (r_state == IDLE) ? mode : r_lrr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_lrr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_acc && !w_clast) begin
        r_g   <= w_cand;
        r_lrr <= mode;
      end
      if (w_acc && w_clast && w_rr_now) begin
        r_ptr <= (w_cand == SELW'(CH - 1)) ? '0 : w_cand + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_ld) begin
      r_out_valid <= w_acc;
      if (w_acc) begin
        r_out_data <= w_cdata;
        r_out_last <= w_clast;
        r_out_ch   <= w_cand;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (CH=8 main instance, CH=5
// instance for out-of-range select and pointer wrap).
module tb_stream_mux_rr;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_last;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic        mode5;
  logic [2:0]  sel5;
  logic [4:0]  valid5;
  logic [39:0] data5;
  logic [4:0]  last5;
  logic [4:0]  in_ready5;
  logic        out_valid5;
  logic [7:0]  out_data5;
  logic        out_last5;
  logic [2:0]  out_ch5;
  logic        out_ready5;

  stream_mux_rr #(.WIDTH(8), .CH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CH(5)) dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode5),
    .sel      (sel5),
    .in_valid (valid5),
    .in_data  (data5),
    .in_last  (last5),
    .in_ready (in_ready5),
    .out_valid(out_valid5),
    .out_data (out_data5),
    .out_last (out_last5),
    .out_ch   (out_ch5),
    .out_ready(out_ready5)
  );

  beat_t srcq [8][$];
  exp_t  sb[$];
  int    n_run = 0;
  int    n_fail = 0;
  int    nbeats = 0;
  int    nb0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic src(int ch, logic [7:0] d, logic l);
    srcq[ch].push_back({d, l});
  endtask

  task automatic exp_beat(int ch, logic [7:0] d, logic l);
    sb.push_back({3'(ch), d, l});
  endtask

  task automatic drive();
    for (int k = 0; k < 8; k++) begin
      in_valid[k] = srcq[k].size() > 0;
      if (in_valid[k]) begin
        in_data[k*8 +: 8] = srcq[k][0].d;
        in_last[k]        = srcq[k][0].l;
      end else begin
        in_data[k*8 +: 8] = 8'h00;
        in_last[k]        = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [7:0] acc;
    exp_t       e;
    @(negedge clk);
    acc = in_valid & in_ready;
    chk("rdy_onehot", 32'($countones(in_ready) <= 1), 1);
    if (out_valid && !out_ready) chk("bp_rdy", in_ready, 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("beat", {out_ch, out_data, out_last}, e);
        nbeats++;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (acc[k]) void'(srcq[k].pop_front());
    end
    drive();
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while (sb.size() > 0 && n < lim) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    mode       = 1'b0;
    sel        = 3'd5;
    out_ready  = 1'b1;
    mode5      = 1'b0;
    sel5       = 3'd0;
    valid5     = '0;
    last5      = '1;
    out_ready5 = 1'b1;
    for (int k = 0; k < 5; k++) data5[k*8 +: 8] = 8'(8'h50 + k);
    for (int k = 0; k < 8; k++) src(k, (k == 5) ? 8'hA5 : 8'(8'h10 + k), 1'b1);
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_rdy", in_ready, 0);

    // fixed select of channel 5
    rst_n = 1'b1;
    #1;
    chk("fix_rdy", in_ready, 8'h20);
    exp_beat(5, 8'hA5, 1'b1);
    tick();
    chk("fix_valid", out_valid, 1);
    chk("fix_data", out_data, 8'hA5);
    chk("fix_ch", out_ch, 5);
    chk("fix_last", out_last, 1);
    foreach (srcq[k]) srcq[k].delete();
    drive();
    drain(5);

    // round-robin fairness, no bubbles
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src(k, 8'(8'h30 + k), 1'b1);
      exp_beat(k, 8'(8'h30 + k), 1'b1);
    end
    src(0, 8'h38, 1'b1);
    exp_beat(0, 8'h38, 1'b1);
    drive();
    nb0 = nbeats;
    repeat (10) tick();
    chk("rr_nobubble", nbeats - nb0, 9);
    drain(5);

    // packet lock with mode/sel change mid-packet
    mode = 1'b0;
    sel  = 3'd2;
    src(2, 8'h21, 1'b0);
    src(2, 8'h22, 1'b0);
    src(2, 8'h23, 1'b1);
    src(3, 8'h31, 1'b1);
    exp_beat(2, 8'h21, 1'b0);
    exp_beat(2, 8'h22, 1'b0);
    exp_beat(2, 8'h23, 1'b1);
    exp_beat(3, 8'h31, 1'b1);
    drive();
    tick();
    mode = 1'b1;
    sel  = 3'd3;
    #1;
    chk("lock_rdy", in_ready, 8'h04);
    drain(20);

    // backpressure for 4 cycles
    mode = 1'b0;
    sel  = 3'd4;
    src(4, 8'hC1, 1'b0);
    src(4, 8'hC2, 1'b1);
    exp_beat(4, 8'hC1, 1'b0);
    exp_beat(4, 8'hC2, 1'b1);
    drive();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'hC1);
    end
    out_ready = 1'b1;
    drain(20);
    repeat (2) tick();

    // reset during beat 2 of a channel-6 packet
    sel = 3'd6;
    src(6, 8'h60, 1'b0);
    src(6, 8'h61, 1'b0);
    src(6, 8'h62, 1'b1);
    exp_beat(6, 8'h60, 1'b0);
    drive();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_ch", out_ch, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_rdy", in_ready, 0);
    foreach (srcq[k]) srcq[k].delete();
    mode = 1'b1;
    src(1, 8'h11, 1'b1);
    src(6, 8'h66, 1'b1);
    exp_beat(1, 8'h11, 1'b1);
    exp_beat(6, 8'h66, 1'b1);
    drive();
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_grant", in_ready, 8'h02);
    drain(20);

    // CH=5: out-of-range select and pointer wrap
    sel5   = 3'd7;
    valid5 = 5'h1F;
    #1;
    chk("u5_oor_rdy", in_ready5, 0);
    tick();
    chk("u5_oor_vld", out_valid5, 0);
    mode5  = 1'b1;
    valid5 = 5'b01000;
    #1;
    chk("u5_rr3", in_ready5, 5'b01000);
    tick();
    valid5 = '0;
    chk("u5_ch3", out_ch5, 3);
    valid5 = 5'b00001;
    #1;
    chk("u5_wrap", in_ready5, 5'b00001);
    tick();
    valid5 = '0;
    chk("u5_ch0", out_ch5, 0);
    chk("u5_data0", out_data5, 8'h50);
    chk("u5_last0", out_last5, 1);
    valid5 = 5'b00011;
    #1;
    chk("u5_ptr1", in_ready5, 5'b00010);
    tick();
    valid5 = '0;
    chk("u5_ch1", out_ch5, 1);
    chk("u5_vld1", out_valid5, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 The block SHALL have parameter CH, default 8, number of input channels, legal range 2..16, not required to be a power of two.
REQ-003 The block SHALL have derived localparam SELW = clog2(CH), the select and channel-id width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port mode, input, 1, selecting arbitration: 0 = fixed select, 1 = round-robin.
REQ-007 The block SHALL have port sel, input, SELW, the channel to use in fixed mode.
REQ-008 The block SHALL have port in_valid, input, CH, per-channel beat valid.
REQ-009 The block SHALL have port in_data, input, CH*WIDTH, packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port in_last, input, CH, per-channel end-of-packet marker.
REQ-011 The block SHALL have port in_ready, output, CH, per-channel accept; at most one bit high in any cycle.
REQ-012 The block SHALL have port out_valid, output, 1, output beat valid.
REQ-013 The block SHALL have port out_data, output, WIDTH, output beat data.
REQ-014 The block SHALL have port out_last, output, 1, output end-of-packet marker.
REQ-015 The block SHALL have port out_ch, output, SELW, source channel of the current output beat.
REQ-016 The block SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-017 A beat SHALL transfer on any interface when valid and ready are both high at a rising clk edge.
REQ-018 The output stage SHALL be one register holding out_valid, out_data, out_last and out_ch, with load enable ld = !out_valid || out_ready.
REQ-019 An accepted input beat SHALL appear on the outputs exactly 1 cycle after acceptance; sustained throughput SHALL be 1 beat/cycle with no bubbles.
REQ-020 The FSM SHALL have two states: IDLE (no packet in progress) and LOCK (granted channel g held).
REQ-021 In IDLE, fixed mode (mode=0): the candidate SHALL be sel when sel < CH and in_valid[sel]=1; otherwise there is no candidate.
REQ-022 In IDLE, round-robin mode (mode=1): the candidate SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ... modulo CH.
REQ-023 in_ready[k] SHALL equal ld && (k == candidate in IDLE, or k == g in LOCK); the path is combinational from in_valid/out_ready and not registered.
REQ-024 Acceptance in IDLE with in_last=0 SHALL latch g and move the FSM to LOCK; with in_last=1 (single-beat packet) the FSM SHALL stay in IDLE.
REQ-025 In LOCK, only channel g SHALL be served; mode, sel and other channels' valids SHALL be ignored until a beat with in_last=1 is accepted from g, after which the FSM returns to IDLE.
REQ-026 ptr SHALL update to (granted+1) mod CH on acceptance of each packet-final beat in round-robin mode, wrapping from CH-1 to 0; it SHALL be unchanged in fixed mode.
REQ-027 A mode or sel change SHALL take effect only for the next IDLE decision; it SHALL never split a packet.
REQ-028 With out_valid=1 and out_ready=0, all outputs SHALL hold stable and in_ready SHALL be all zero.
REQ-029 A channel withdrawing in_valid mid-packet SHALL stall the output without releasing LOCK.

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, ptr=0 and g=0; in_ready SHALL be 0 while rst_n is low.
REQ-031 Reset mid-packet SHALL abandon the packet; after reset release the first decision SHALL be made from IDLE with ptr=0.

Structure
REQ-032 A shared package mux_pkg SHALL hold the FSM state enum (IDLE, LOCK) and the default WIDTH/CH constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, ptr; outputs: found, index), purely combinational and parametrised by CH.
REQ-034 No latches SHALL be inferred, and all registers SHALL use the asynchronous active-low rst_n.

Verification (WIDTH=8, CH=8)
REQ-035 Fixed mode: mode=0, sel=5, in_valid=8'hFF, ch5 data=8'hA5 with last=1, out_ready=1 -> only in_ready[5] high; next cycle out_data=8'hA5, out_ch=5, out_last=1.
REQ-036 Round-robin fairness: mode=1, all channels valid with single-beat packets, out_ready=1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles with no bubbles.
REQ-037 Packet lock: ch2 sends a 3-beat packet (last on beat 3) while ch3 is valid -> out_ch=2 for 3 beats, then 3; changing sel/mode mid-packet has no effect.
REQ-038 Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data stable and in_ready=0 throughout; each beat is output exactly once after out_ready returns.
REQ-039 Reset mid-packet: assert rst_n=0 during beat 2 of a ch6 packet -> outputs are 0 immediately; after release with mode=1, ch1 and ch6 valid -> ch1 is granted first (ptr=0).
REQ-040 Out-of-range/wrap: CH=5 instance, mode=0, sel=7 -> no grant; mode=1 with ptr=4 and only ch0 valid -> ch0 granted and ptr becomes 1.
